register_mult_pipe: RTL and testbench
=====================================

Name: register_mult_pipe

Overview:
- Parametrised elastic pipeline register for the FPU multiplier datapath: a chain of STAGES load-gated registers, each with a valid bit and valid/ready back-pressure.
- Successor to the single load-enable register; adds depth, handshaking, flush and occupancy reporting.
- Sits between multiplier partial-product/normalisation stages, so operand, product and sign/exponent fields can be retimed without hand-written stall logic.

Parameters:
- W, 16, data width in bits (>=1)
- STAGES, 2, number of register stages (>=1)
- CLEAR_DATA, 1, 1 = data registers zeroed on reset/flush; 0 = only valid bits cleared (data holds)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-low reset (sampled on rising clk; rst=0 resets)
- flush  in  1  synchronous pipeline clear
- in_valid  in  1  upstream data valid
- in_ready  out  1  pipe accepts in_data this cycle
- in_data  in  W  upstream data
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts
- out_data  out  W  data from last stage
- occupancy  out  $clog2(STAGES+1)  number of valid stages

Behaviour:
- Stage k (0..STAGES-1) holds data[k] and v[k]. Stage 0 is fed by the input; stage STAGES-1 drives the outputs.
- Ready chain (combinational):
  - adv[last] = out_ready | !v[last]
  - adv[k] = adv[k+1] | !v[k]
  - in_ready = adv[0] & !flush
- Per-stage update on a clock edge:
  - When adv[k]=1, stage k loads from its predecessor: data[k] <= data[k-1], v[k] <= v[k-1]. For k=0 the predecessor is the input, gated as v <= in_valid & in_ready.
  - When adv[k]=0, stage k holds.
  - The data register loads only when its predecessor's valid is 1 (power gating). A bubble advancing clears v but leaves data unchanged.
- Transfers:
  - Input transfer = in_valid & in_ready.
  - Output transfer = out_valid & out_ready.
- Latency: exactly STAGES cycles from input transfer to out_valid when there is no back-pressure. Throughput is 1 item/cycle with out_ready held high.
- Simultaneous input and output transfer with a full pipe is legal: every stage shifts and occupancy is unchanged.
- out_valid = v[last] & !flush. out_data = data[last] (registered, no combinational path from in_data).
- occupancy = popcount(v), registered-state based. It is 0 after reset and STAGES when full.
- Data ordering: FIFO order is preserved, with no duplication or loss under any out_ready pattern.
- Holding rule: while out_valid=1 and out_ready=0, out_data and out_valid are stable.
- flush=1 (with rst=1):
  - All v cleared on the next edge.
  - Data cleared to 0 if CLEAR_DATA=1.
  - in_ready=0 and out_valid=0 during the flush cycle, so no transfer occurs.
  - in_valid is ignored that cycle.
- rst=0:
  - All v <= 0, occupancy 0.
  - Data <= 0 if CLEAR_DATA=1.
  - Priority over flush and any transfer.
  - Reset mid-stream discards all in-flight items.
- Outputs during and immediately after reset: out_valid=0, in_ready=1 (if flush=0), out_data=0 when CLEAR_DATA=1.
- STAGES=1 degenerates to a single elastic register with the same rules.

Decomposition:
- Shared package fpu_pipe_pkg:
  - function cnt_width(n) returning $clog2(n+1)
  - localparam defaults for W_MULT_DATA
- One sub-module, register_mult_stage (W, CLEAR_DATA):
  - Ports: clk, rst, flush, adv, in_v, in_d, v, d.
- register_mult_pipe instantiates it STAGES times in a generate loop and holds the ready chain and popcount.

Test Plan (W=16, STAGES=3, CLEAR_DATA=1 unless stated):
- Reset/idle: drive rst=0 for 2 cycles, then release -> out_valid=0, occupancy=0, out_data=16'h0000, in_ready=1.
- Streaming: push 16'h0001..16'h0008 on consecutive cycles with out_ready=1 -> 16'h0001 appears on the 3rd edge after its transfer, one word per cycle thereafter, in order; occupancy settles at 3.
- Back-pressure: push 16'hA000..16'hA004 with out_ready=0 -> after 3 accepted words in_ready=0 and occupancy=3; out_data holds 16'hA000. Then raise out_ready for 1 cycle -> 16'hA000 leaves, 16'hA003 is accepted the same cycle, and occupancy stays 3.
- Bubbles: alternate in_valid 1/0 with values 16'h1111, 16'h2222, 16'h3333, out_ready=1 -> outputs 1111, 2222, 3333 each separated by one out_valid=0 cycle; occupancy never exceeds 2.
- Flush: fill with 16'hBEEF, 16'hCAFE, 16'hF00D, then assert flush for 1 cycle with in_valid=1 and data 16'h1234 -> in_ready=0 and out_valid=0 that cycle; next cycle occupancy=0 and data regs=0; 16'h1234 never emerges.
- Reset mid-operation with CLEAR_DATA=0: with 2 items in flight, drive rst=0 for 1 cycle -> occupancy=0 and out_valid=0; out_data keeps its last value; subsequent push 16'h0042 emerges after 3 cycles.

Source files
------------

// File: rtl/fpu_pipe_pkg.sv
// Shared definitions for the FPU multiplier pipeline registers.
package fpu_pipe_pkg;

   // Default datapath width and depth used by the multiplier retiming registers.
   localparam int unsigned W_MULT_DATA = 16;
   localparam int unsigned STAGES_MULT = 2;

   // Bits needed to count 0..n inclusive.
   function automatic int unsigned cnt_width(input int unsigned n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/register_mult_stage.sv
// One load-gated elastic register stage: valid bit plus data word.
module register_mult_stage
   import fpu_pipe_pkg::*;
#(
   parameter int unsigned W          = W_MULT_DATA,
   parameter bit          CLEAR_DATA = 1'b1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush,
   input  logic         adv,
   input  logic         in_v,
   input  logic [W-1:0] in_d,
   output logic         v,
   output logic [W-1:0] d
);

   logic         valid_q, valid_d;
   logic [W-1:0] data_q, data_d;

   // Next state: flush clears, advance takes predecessor; data only loads behind a valid word.
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (flush) begin
         valid_d = 1'b0;
         if (CLEAR_DATA) data_d = '0;
      end else if (adv) begin
         valid_d = in_v;
         if (in_v) data_d = in_d;
      end
   end

   // State register with synchronous active-low reset taking priority over everything.
   always_ff @(posedge clk) begin
      if (!rst) begin
         valid_q <= 1'b0;
         if (CLEAR_DATA) data_q <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign v = valid_q;
   assign d = data_q;

endmodule

// File: rtl/register_mult_pipe.sv
// Elastic multi-stage pipeline register with valid/ready, flush and occupancy.
module register_mult_pipe
   import fpu_pipe_pkg::*;
#(
   parameter int unsigned W          = W_MULT_DATA,
   parameter int unsigned STAGES     = STAGES_MULT,
   parameter bit          CLEAR_DATA = 1'b1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          flush,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [W-1:0]                  in_data,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [W-1:0]                  out_data,
   output logic [cnt_width(STAGES)-1:0]  occupancy
);

   localparam int unsigned OCC_W = cnt_width(STAGES);

   logic [STAGES-1:0] adv;
   logic [STAGES-1:0] v;
   logic [W-1:0]      d [STAGES];
   logic              in_xfer;

   // The recursive ready chain is flattened: stage k may advance when the
   // output drains or any stage from k to the output holds a bubble.
   for (genvar k = 0; k < STAGES; k++) begin : g_adv
      assign adv[k] = out_ready | ~(&v[STAGES-1:k]);
   end

   assign in_ready = adv[0] & ~flush;
   assign in_xfer  = in_valid & in_ready;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic         stg_in_v;
      logic [W-1:0] stg_in_d;

      if (k == 0) begin : g_head
         assign stg_in_v = in_xfer;
         assign stg_in_d = in_data;
      end else begin : g_body
         assign stg_in_v = v[k-1];
         assign stg_in_d = d[k-1];
      end

      register_mult_stage #(
         .W          (W),
         .CLEAR_DATA (CLEAR_DATA)
      ) u_stage (
         .clk   (clk),
         .rst   (rst),
         .flush (flush),
         .adv   (adv[k]),
         .in_v  (stg_in_v),
         .in_d  (stg_in_d),
         .v     (v[k]),
         .d     (d[k])
      );
   end

   // Occupancy is the popcount of the registered valid bits.
   always_comb begin
      occupancy = '0;
      for (int unsigned i = 0; i < STAGES; i++) begin
         occupancy = occupancy + OCC_W'(v[i]);
      end
   end

   assign out_valid = v[STAGES-1] & ~flush;
   assign out_data  = d[STAGES-1];

endmodule

// File: tb/tb_register_mult_pipe.sv
// Randomised and directed bench for register_mult_pipe against a queue-based model.
module tb_register_mult_pipe;

   localparam int unsigned W      = 16;
   localparam int unsigned STAGES = 3;

   logic         clk = 1'b0;
   logic         rst, flush, in_valid, out_ready;
   logic [W-1:0] in_data;

   logic         in_ready_c, out_valid_c, in_ready_n, out_valid_n;
   logic [W-1:0] out_data_c, out_data_n;
   logic [1:0]   occ_c, occ_n;

   always #5 clk = ~clk;

   register_mult_pipe #(.W(W), .STAGES(STAGES), .CLEAR_DATA(1'b1)) u_dut_clr (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_c),
      .in_data(in_data), .out_valid(out_valid_c), .out_ready(out_ready),
      .out_data(out_data_c), .occupancy(occ_c));

   register_mult_pipe #(.W(W), .STAGES(STAGES), .CLEAR_DATA(1'b0)) u_dut_nc (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_n),
      .in_data(in_data), .out_valid(out_valid_n), .out_ready(out_ready),
      .out_data(out_data_n), .occupancy(occ_n));

   // Model: FIFO of in-flight words stamped with the edge that accepted them.
   // The oldest word is never blocked, so it sits at the output once it is
   // STAGES-1 edges old.
   typedef struct {
      logic [W-1:0] data;
      int unsigned  acc;
   } item_t;

   item_t        q[$];
   int unsigned  cyc      = 0;
   logic [W-1:0] last_c   = '0;
   logic [W-1:0] last_n   = '0;
   bit           known_n  = 1'b0;
   bit           checking = 1'b0;
   int unsigned  n_checks = 0;
   int unsigned  n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   function automatic bit head_at_out();
      return (q.size() > 0) && ((cyc - q[0].acc) >= STAGES - 1);
   endfunction

   task automatic step(output bit accepted);
      bit    exp_ir, exp_ov;
      item_t it;
      exp_ir = !flush && ((q.size() < STAGES) || out_ready);
      exp_ov = !flush && head_at_out();
      if (checking) begin
         check("in_ready",     in_ready_c,  exp_ir);
         check("out_valid",    out_valid_c, exp_ov);
         check("occupancy",    occ_c,       q.size());
         check("out_data",     out_data_c,  last_c);
         check("in_ready_nc",  in_ready_n,  exp_ir);
         check("out_valid_nc", out_valid_n, exp_ov);
         check("occupancy_nc", occ_n,       q.size());
         if (known_n) check("out_data_nc", out_data_n, last_n);
      end
      accepted = rst && exp_ir && in_valid;
      @(posedge clk);
      cyc++;
      if (!rst || flush) begin
         q.delete();
         last_c = '0;
      end else begin
         if (exp_ov && out_ready) void'(q.pop_front());
         if (exp_ir && in_valid) begin
            it.data = in_data;
            it.acc  = cyc;
            q.push_back(it);
         end
      end
      if (head_at_out()) begin
         last_c  = q[0].data;
         last_n  = q[0].data;
         known_n = 1'b1;
      end
      #1;
   endtask

   task automatic drive(input bit iv, input logic [W-1:0] dat, input bit ordy,
                        input bit fl, input bit rs, output bit accepted);
      in_valid  = iv;
      in_data   = dat;
      out_ready = ordy;
      flush     = fl;
      rst       = rs;
      #1;
      step(accepted);
   endtask

   task automatic idle(input int unsigned n, input bit ordy);
      bit a;
      for (int unsigned i = 0; i < n; i++) drive(1'b0, '0, ordy, 1'b0, 1'b1, a);
   endtask

   initial begin
      bit           a;
      int unsigned  idx, lat;
      logic [W-1:0] vals [3];
      vals[0] = 16'h1111; vals[1] = 16'h2222; vals[2] = 16'h3333;

      // Reset / idle
      drive(1'b0, '0, 1'b0, 1'b0, 1'b0, a);
      drive(1'b0, '0, 1'b0, 1'b0, 1'b0, a);
      checking = 1'b1;
      rst = 1'b1;
      #1;
      check("rst_out_valid", out_valid_c, 0);
      check("rst_occ",       occ_c,       0);
      check("rst_out_data",  out_data_c,  16'h0000);
      check("rst_in_ready",  in_ready_c,  1);
      idle(2, 1'b1);

      // Streaming 1..8 at full rate
      idx = 1;
      for (int unsigned t = 0; t < 20 && idx <= 8; t++) begin
         drive(1'b1, W'(idx), 1'b1, 1'b0, 1'b1, a);
         if (a) idx++;
      end
      check("stream_all_pushed", idx, 9);
      check("stream_occ", occ_c, 3);
      idle(5, 1'b1);

      // Back-pressure
      idx = 0;
      for (int unsigned t = 0; t < 5; t++) begin
         drive(1'b1, 16'hA000 + W'(idx), 1'b0, 1'b0, 1'b1, a);
         if (a) idx++;
      end
      check("bp_accepted", idx, 3);
      check("bp_in_ready", in_ready_c, 0);
      check("bp_occ", occ_c, 3);
      check("bp_hold", out_data_c, 16'hA000);
      drive(1'b1, 16'hA003, 1'b1, 1'b0, 1'b1, a);
      check("bp_swap_accept", a, 1);
      check("bp_swap_occ", occ_c, 3);
      check("bp_next_head", out_data_c, 16'hA001);
      idle(5, 1'b1);

      // Bubbles
      for (int unsigned i = 0; i < 3; i++) begin
         drive(1'b1, vals[i], 1'b1, 1'b0, 1'b1, a);
         check("bubble_occ_max", occ_c <= 2, 1);
         drive(1'b0, '0, 1'b1, 1'b0, 1'b1, a);
         check("bubble_occ_max", occ_c <= 2, 1);
      end
      idle(4, 1'b1);

      // Flush with a word offered during the flush cycle
      drive(1'b1, 16'hBEEF, 1'b0, 1'b0, 1'b1, a);
      drive(1'b1, 16'hCAFE, 1'b0, 1'b0, 1'b1, a);
      drive(1'b1, 16'hF00D, 1'b0, 1'b0, 1'b1, a);
      in_valid = 1'b1; in_data = 16'h1234; flush = 1'b1; #1;
      check("flush_in_ready", in_ready_c, 0);
      check("flush_out_valid", out_valid_c, 0);
      step(a);
      flush = 1'b0; in_valid = 1'b0; #1;
      check("flush_occ", occ_c, 0);
      check("flush_data_zero", out_data_c, 16'h0000);
      idle(5, 1'b1);

      // Reset mid-stream, then a fresh word
      drive(1'b1, 16'h5555, 1'b0, 1'b0, 1'b1, a);
      drive(1'b1, 16'h6666, 1'b0, 1'b0, 1'b1, a);
      drive(1'b0, '0, 1'b0, 1'b0, 1'b0, a);
      rst = 1'b1; #1;
      check("midrst_occ", occ_n, 0);
      check("midrst_out_valid", out_valid_n, 0);
      drive(1'b1, 16'h0042, 1'b1, 1'b0, 1'b1, a);
      check("midrst_push", a, 1);
      lat = 0;
      for (int unsigned t = 1; t <= 6 && lat == 0; t++) begin
         drive(1'b0, '0, 1'b1, 1'b0, 1'b1, a);
         if (out_valid_n && out_data_n == 16'h0042) lat = t;
      end
      check("lat_0042", lat, STAGES - 1);
      idle(3, 1'b1);

      // Random traffic with occasional flush and reset
      for (int unsigned t = 0; t < 600; t++) begin
         drive(1'($urandom_range(0, 1)), W'($urandom), ($urandom_range(0, 9) < 7),
               ($urandom_range(0, 31) == 0), ($urandom_range(0, 63) != 0), a);
      end
      idle(6, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule
